uart_tx_arbiter: RTL and testbench

Shares one UART_TX_CTRL byte transmitter between NUM_REQ message sources such as the button-triggered "ARTY A7\n" sender, status reporters and echo paths.
Arbitration is round-robin and message-atomic: a granted requester owns the transmitter until it sends a byte flagged LAST, or until it stalls past a timeout.
The block sequences the transmitter's SEND/READY handshake, so requesters see only a simple valid/ack byte interface.

---
 rtl/uart_tx_arbiter_pkg.sv | 21 ++
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM state encoding and the counter-width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_GUARD    = 3'd2,
    ST_WAIT_RDY = 3'd3
  } arb_state_e;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_GUARD_CYCLES = 2;
  localparam int DEF_HOLD_TIMEOUT = 1024;

  // Bits needed to count 0..max_val. Never returns less than 1.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority encoder: selects the first set request at or above ptr.
// The search wraps modulo N, so it works for N values that are not powers of two.
module uart_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  always_comb begin
    logic [W-1:0] k;
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    k      = '0;
    for (int i = 0; i < N; i++) begin
      k = W'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        found     = 1'b1;
        idx       = k;
        onehot    = '0;
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter that shares one UART byte transmitter.
// It sequences the transmitter's SEND/READY handshake behind a valid/ack byte port.
//
// state       | meaning
// ST_IDLE     | no owner; pick the next requester round-robin
// ST_ISSUE    | owner granted; send its byte once TX_READY is high
// ST_GUARD    | SEND just issued; TX_READY ignored while it drops
// ST_WAIT_RDY | wait for the byte to finish, then release or continue
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   REQ_ACK,
  output logic [NUM_REQ-1:0]   GRANT,
  output logic                 BUSY,
  output logic                 TX_SEND,
  output logic [7:0]           TX_DATA,
  input  logic                 TX_READY
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = cnt_width(GUARD_CYCLES);
  localparam int TW = cnt_width(HOLD_TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               send_q, send_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic [GW-1:0]      guard_cnt_q, guard_cnt_d;
  logic [TW-1:0]      to_cnt_q, to_cnt_d;
  logic               busy_q, busy_d;

  logic [7:0]         req_byte [NUM_REQ];
  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_byte[i] = REQ_DATA[8*i +: 8];
  end

  uart_rr_pick #(
    .N (NUM_REQ),
    .W (IW)
  ) u_pick (
    .req    (REQ_VALID),
    .ptr    (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Explicit wrap so non-power-of-two NUM_REQ never lands on an unused index.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] v);
    return (v == IW'(NUM_REQ - 1)) ? '0 : v + IW'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    ack_d       = '0;
    send_d      = 1'b0;
    data_d      = data_q;
    last_d      = last_q;
    guard_cnt_d = guard_cnt_q;
    to_cnt_d    = to_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d  = ST_ISSUE;
          owner_d  = pick_idx;
          grant_d  = pick_onehot;
          to_cnt_d = '0;
        end
      end
      ST_ISSUE: begin
        if (REQ_VALID[owner_q]) begin
          to_cnt_d = '0;
          if (TX_READY) begin
            send_d          = 1'b1;
            data_d          = req_byte[owner_q];
            ack_d[owner_q]  = 1'b1;
            last_d          = REQ_LAST[owner_q];
            guard_cnt_d     = GW'(GUARD_CYCLES);
            state_d         = ST_GUARD;
          end
        end else begin
          if (to_cnt_q != '1) to_cnt_d = to_cnt_q + TW'(1);
          // A stalled owner loses the lock without its message completing.
          if ((HOLD_TIMEOUT != 0) && (to_cnt_d == TW'(HOLD_TIMEOUT))) begin
            grant_d  = '0;
            rr_ptr_d = next_idx(owner_q);
            state_d  = ST_IDLE;
            to_cnt_d = '0;
          end
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q <= GW'(1)) state_d = ST_WAIT_RDY;
        else                       guard_cnt_d = guard_cnt_q - GW'(1);
      end
      ST_WAIT_RDY: begin
        if (TX_READY) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = next_idx(owner_q);
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_ISSUE;
            to_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      send_q      <= 1'b0;
      data_q      <= 8'h00;
      last_q      <= 1'b0;
      guard_cnt_q <= '0;
      to_cnt_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      send_q      <= send_d;
      data_q      <= data_d;
      last_q      <= last_d;
      guard_cnt_q <= guard_cnt_d;
      to_cnt_q    <= to_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign REQ_ACK = ack_q;
  assign GRANT   = grant_q;
  assign BUSY    = busy_q;
  assign TX_SEND = send_q;
  assign TX_DATA = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a byte-time UART model,
// and a message-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int G  = 2;
  localparam int HT = 16;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   REQ_VALID;
  logic [8*N-1:0] REQ_DATA;
  logic [N-1:0]   REQ_LAST;
  logic [N-1:0]   REQ_ACK;
  logic [N-1:0]   GRANT;
  logic           BUSY;
  logic           TX_SEND;
  logic [7:0]     TX_DATA;
  logic           TX_READY;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .GUARD_CYCLES (G),
    .HOLD_TIMEOUT (HT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
    .REQ_LAST  (REQ_LAST),
    .REQ_ACK   (REQ_ACK),
    .GRANT     (GRANT),
    .BUSY      (BUSY),
    .TX_SEND   (TX_SEND),
    .TX_DATA   (TX_DATA),
    .TX_READY  (TX_READY)
  );

  typedef struct {
    int         owner;
    logic [7:0] data;
  } sent_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] req_q [N][$];
  sent_t      sent_log[$];
  int         ack_cnt [N];
  bit         rdy_hold = 0;
  bit         mon_en = 0;
  int         byte_time = 4;
  int         busy_cnt = 0;

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (req_q[i].size() != 0) return 0;
    return 1;
  endfunction

  // Protocol monitor: ack/send pairing, grant one-hot, BUSY vs GRANT; logs every SEND.
  always @(negedge CLK) begin
    if (mon_en) begin
      n_cmp++;
      if ((TX_SEND != (REQ_ACK != '0)) || ($countones(REQ_ACK) > 1) || ((REQ_ACK & ~GRANT) != '0)) begin
        n_bad++;
        $display("FAIL ack_rule: ack=%b send=%b grant=%b", REQ_ACK, TX_SEND, GRANT);
      end
      n_cmp++;
      if (($countones(GRANT) > 1) || (BUSY !== (GRANT != '0))) begin
        n_bad++;
        $display("FAIL grant_busy: grant=%b busy=%b", GRANT, BUSY);
      end
      if (TX_SEND) begin
        sent_t e;
        e.owner = oh2idx(GRANT);
        e.data  = TX_DATA;
        sent_log.push_back(e);
      end
      for (int i = 0; i < N; i++) if (REQ_ACK[i]) ack_cnt[i]++;
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (req_q[i].size() > 0) begin
        REQ_VALID[i]         = 1'b1;
        REQ_DATA[8*i +: 8]   = req_q[i][0][7:0];
        REQ_LAST[i]          = req_q[i][0][8];
      end else begin
        REQ_VALID[i]         = 1'b0;
        REQ_DATA[8*i +: 8]   = 8'h00;
        REQ_LAST[i]          = 1'b0;
      end
    end
    TX_READY = (busy_cnt == 0) && !rdy_hold;
  endtask

  // One clock: requesters pop on ACK, UART model goes busy for byte_time after SEND.
  task automatic tick();
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++)
      if (REQ_ACK[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
    if (TX_SEND) busy_cnt = byte_time;
    else if (busy_cnt > 0) busy_cnt--;
    drive();
  endtask

  task automatic begin_reset();
    RST = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_q[i].delete();
      ack_cnt[i] = 0;
    end
    sent_log.delete();
    rdy_hold = 0;
    busy_cnt = 0;
    drive();
    tick();
    tick();
  endtask

  task automatic run_idle(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (all_empty() && GRANT == '0 && !TX_SEND && busy_cnt == 0) begin
        ok = 1;
        break;
      end
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    begin_reset();
    tick();
    mon_en = 1;
    n_cmp++; if (GRANT !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", GRANT); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (TX_SEND !== 1'b0) begin n_bad++; $display("FAIL reset_send: got %b want 0", TX_SEND); end
    n_cmp++; if (REQ_ACK !== 4'b0000) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", REQ_ACK); end
    n_cmp++; if (TX_DATA !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", TX_DATA); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_byte_flow();
    logic [7:0] msg [8];
    bit ok;
    msg = '{8'h41, 8'h52, 8'h54, 8'h59, 8'h20, 8'h41, 8'h37, 8'h0A};
    begin_reset();
    byte_time = $urandom_range(3, 12);
    for (int i = 0; i < 8; i++) req_q[0].push_back({(i == 7), msg[i]});
    RST = 1'b0;
    drive();
    run_idle(2000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL flow_timeout: got stuck want idle"); end
    n_cmp++; if (sent_log.size() != 8) begin n_bad++; $display("FAIL flow_count: got %0d want 8", sent_log.size()); end
    for (int i = 0; i < 8 && i < sent_log.size(); i++) begin
      n_cmp++;
      if (sent_log[i].owner != 0 || sent_log[i].data !== msg[i]) begin
        n_bad++;
        $display("FAIL flow_byte%0d: got r%0d/%h want r0/%h", i, sent_log[i].owner, sent_log[i].data, msg[i]);
      end
    end
    n_cmp++; if (ack_cnt[0] != 8) begin n_bad++; $display("FAIL flow_acks: got %0d want 8", ack_cnt[0]); end
    n_cmp++; if (GRANT !== 4'b0000) begin n_bad++; $display("FAIL flow_release: got %b want 0000", GRANT); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [4];
    logic [7:0]   exp_d [4];
    logic [N-1:0] gseq[$];
    logic [N-1:0] prev;
    exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    exp_d = '{8'hA0, 8'hC0, 8'hA1, 8'hC1};
    begin_reset();
    byte_time = 3;
    req_q[0].push_back({1'b1, 8'hA0}); req_q[0].push_back({1'b1, 8'hA1});
    req_q[2].push_back({1'b1, 8'hC0}); req_q[2].push_back({1'b1, 8'hC1});
    RST = 1'b0;
    drive();
    prev = '0;
    for (int c = 0; c < 400 && !(all_empty() && GRANT == '0 && !BUSY); c++) begin
      tick();
      if (GRANT != '0 && prev == '0) gseq.push_back(GRANT);
      prev = GRANT;
    end
    tick();
    tick();
    n_cmp++; if (gseq.size() != 4) begin n_bad++; $display("FAIL rr_grants: got %0d want 4", gseq.size()); end
    for (int i = 0; i < 4 && i < gseq.size(); i++) begin
      n_cmp++;
      if (gseq[i] !== exp_g[i]) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", i, gseq[i], exp_g[i]); end
    end
    for (int i = 0; i < 4 && i < sent_log.size(); i++) begin
      n_cmp++;
      if (sent_log[i].data !== exp_d[i]) begin n_bad++; $display("FAIL rr_data%0d: got %h want %h", i, sent_log[i].data, exp_d[i]); end
    end
  endtask

  task automatic test_atomicity();
    int  exp_o [4];
    bit  early;
    bit  ok;
    exp_o = '{1, 1, 1, 3};
    begin_reset();
    byte_time = $urandom_range(2, 8);
    for (int i = 0; i < 3; i++) req_q[1].push_back({(i == 2), 8'($urandom)});
    req_q[3].push_back({1'b1, 8'($urandom)});
    RST = 1'b0;
    drive();
    early = 0;
    ok = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (GRANT[3] && req_q[1].size() != 0) early = 1;
      if (all_empty() && GRANT == '0 && busy_cnt == 0) begin ok = 1; break; end
    end
    tick();
    tick();
    n_cmp++; if (!ok || early) begin n_bad++; $display("FAIL atomic_lock: got early=%0d done=%0d want 0/1", early, ok); end
    n_cmp++; if (sent_log.size() != 4) begin n_bad++; $display("FAIL atomic_count: got %0d want 4", sent_log.size()); end
    for (int i = 0; i < 4 && i < sent_log.size(); i++) begin
      n_cmp++;
      if (sent_log[i].owner != exp_o[i]) begin n_bad++; $display("FAIL atomic_owner%0d: got %0d want %0d", i, sent_log[i].owner, exp_o[i]); end
    end
  endtask

  task automatic test_timeout();
    int k;
    bit ok;
    begin_reset();
    byte_time = 1;
    req_q[2].push_back({1'b0, 8'($urandom)});
    RST = 1'b0;
    drive();
    k = 0;
    while (!TX_SEND && k < 50) begin tick(); k++; end
    n_cmp++; if (!TX_SEND) begin n_bad++; $display("FAIL to_first_send: got none want send"); end
    n_cmp++; if (GRANT !== 4'b0100) begin n_bad++; $display("FAIL to_owner: got %b want 0100", GRANT); end
    k = 0;
    while (GRANT != '0 && k < 200) begin tick(); k++; end
    // From the SEND cycle: G guard cycles, one WAIT_RDY cycle, then HT stalled ISSUE cycles.
    n_cmp++; if (k != G + 1 + HT) begin n_bad++; $display("FAIL to_release: got %0d cycles want %0d", k, G + 1 + HT); end
    for (int i = 0; i < 10; i++) tick();
    n_cmp++; if (ack_cnt[2] != 1) begin n_bad++; $display("FAIL to_acks: got %0d want 1", ack_cnt[2]); end
    req_q[0].push_back({1'b1, 8'h5A});
    req_q[3].push_back({1'b1, 8'hA5});
    drive();
    k = 0;
    while (GRANT == '0 && k < 10) begin tick(); k++; end
    n_cmp++; if (GRANT !== 4'b1000) begin n_bad++; $display("FAIL to_rr_ptr: got %b want 1000", GRANT); end
    run_idle(500, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_drain: got stuck want idle"); end
  endtask

  task automatic test_ready();
    int  k;
    int  sends;
    bit  ok;
    logic [7:0] b1;
    b1 = 8'($urandom);
    begin_reset();
    byte_time = 1;
    req_q[0].push_back({1'b0, 8'h11});
    req_q[0].push_back({1'b1, b1});
    RST = 1'b0;
    drive();
    k = 0;
    while (!TX_SEND && k < 50) begin tick(); k++; end
    rdy_hold = 1;
    drive();
    sends = 0;
    for (int i = 0; i < 50; i++) begin tick(); if (TX_SEND) sends++; end
    n_cmp++; if (sends != 0) begin n_bad++; $display("FAIL rdy_hold: got %0d sends want 0", sends); end
    rdy_hold = 0;
    drive();
    k = 0;
    while (!TX_SEND && k < 20) begin tick(); k++; end
    // READY seen at the first edge (WAIT_RDY->ISSUE), SEND registered at the next.
    n_cmp++; if (k != 2) begin n_bad++; $display("FAIL rdy_latency: got %0d want 2", k); end
    n_cmp++; if (TX_DATA !== b1) begin n_bad++; $display("FAIL rdy_data: got %h want %h", TX_DATA, b1); end
    run_idle(200, ok);
  endtask

  task automatic test_reset_mid();
    int  k;
    int  sends;
    bit  ok;
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    begin_reset();
    byte_time = 20;
    for (int i = 0; i < 4; i++) req_q[1].push_back({(i == 3), b[i]});
    RST = 1'b0;
    drive();
    k = 0;
    while (!TX_SEND && k < 50) begin tick(); k++; end
    for (int i = 0; i < 4; i++) tick();
    RST = 1'b1;
    tick();
    n_cmp++; if (GRANT !== 4'b0000) begin n_bad++; $display("FAIL mid_grant: got %b want 0000", GRANT); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", BUSY); end
    n_cmp++; if (TX_SEND !== 1'b0 || REQ_ACK !== 4'b0000) begin n_bad++; $display("FAIL mid_send: got %b/%b want 0/0000", TX_SEND, REQ_ACK); end
    n_cmp++; if (TX_DATA !== 8'h00) begin n_bad++; $display("FAIL mid_data: got %h want 00", TX_DATA); end
    RST = 1'b0;
    tick();
    n_cmp++; if (GRANT !== 4'b0010) begin n_bad++; $display("FAIL mid_regrant: got %b want 0010", GRANT); end
    sends = 0;
    k = 0;
    while (busy_cnt > 0 && k < 100) begin tick(); k++; if (TX_SEND) sends++; end
    n_cmp++; if (sends != 0) begin n_bad++; $display("FAIL mid_inflight: got %0d sends want 0", sends); end
    k = 0;
    while (!TX_SEND && k < 20) begin tick(); k++; end
    n_cmp++; if (TX_DATA !== b[1]) begin n_bad++; $display("FAIL mid_resume: got %h want %h", TX_DATA, b[1]); end
    run_idle(500, ok);
  endtask

  task automatic test_random(input int rounds);
    int         mlen [N][$];
    logic [7:0] bcopy [N][$];
    int         exp_o[$];
    logic [7:0] exp_b[$];
    int         mi [N];
    int         pos [N];
    int         ptr;
    int         r;
    int         left;
    bit         ok;
    for (int rd = 0; rd < rounds; rd++) begin
      begin_reset();
      byte_time = $urandom_range(1, 8);
      left = 0;
      exp_o.delete();
      exp_b.delete();
      for (int i = 0; i < N; i++) begin
        int nm;
        mlen[i].delete();
        bcopy[i].delete();
        mi[i] = 0;
        pos[i] = 0;
        nm = $urandom_range(0, 3);
        if (i == 0 && nm == 0) nm = 1;
        for (int m = 0; m < nm; m++) begin
          int len;
          len = $urandom_range(1, 4);
          mlen[i].push_back(len);
          left++;
          for (int j = 0; j < len; j++) begin
            logic [7:0] v;
            v = 8'($urandom);
            bcopy[i].push_back(v);
            req_q[i].push_back({(j == len - 1), v});
          end
        end
      end
      // Reference: whole messages in round-robin order, pointer one past the last sender.
      ptr = 0;
      while (left > 0) begin
        r = -1;
        for (int s = 0; s < N && r < 0; s++)
          if (mi[(ptr + s) % N] < mlen[(ptr + s) % N].size()) r = (ptr + s) % N;
        for (int j = 0; j < mlen[r][mi[r]]; j++) begin
          exp_o.push_back(r);
          exp_b.push_back(bcopy[r][pos[r]]);
          pos[r]++;
        end
        mi[r]++;
        left--;
        ptr = (r + 1) % N;
      end
      RST = 1'b0;
      drive();
      run_idle(6000, ok);
      n_cmp++;
      if (!ok || sent_log.size() != exp_b.size()) begin
        n_bad++;
        $display("FAIL rand%0d_count: got %0d done=%0d want %0d", rd, sent_log.size(), ok, exp_b.size());
      end
      for (int i = 0; i < exp_b.size() && i < sent_log.size(); i++) begin
        n_cmp++;
        if (sent_log[i].owner != exp_o[i] || sent_log[i].data !== exp_b[i]) begin
          n_bad++;
          $display("FAIL rand%0d_byte%0d: got r%0d/%h want r%0d/%h", rd, i, sent_log[i].owner, sent_log[i].data, exp_o[i], exp_b[i]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    REQ_VALID = '0;
    REQ_DATA  = '0;
    REQ_LAST  = '0;
    TX_READY  = 1'b1;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    test_reset();
    test_byte_flow();
    test_round_robin();
    test_atomicity();
    test_timeout();
    test_ready();
    test_reset_mid();
    test_random(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
